sequence_detector_n: RTL and testbench

- Parametrised successor to the key-line sequence detector in the TVP5147M1 decoder interface.
- Receives interleaved 4:2:2 samples (Cb Y Cr Y) during a keyed window and selects luma only.
- Slices each luma sample through a hysteresis (Schmitt) comparator, then majority-votes SAMPLES_PER_BIT samples into one bit.
- Assembles SEQ_BITS bits into a scrambler key word for the sequence management logic, with load, valid and abort reporting.

---
 rtl/sequence_detector_n.sv | 174 +++++++++++++++++
 tb/tb_sequence_detector_n.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/sequence_detector_n.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// sequence_detector_n : luma slicer, bit integrator and key-word assembler
// Revision: 1.0
// ============================================================================
module sequence_detector_n #(
   parameter int DATA_WIDTH      = 10,
   parameter int SEQ_BITS        = 32,
   parameter int SAMPLES_PER_BIT = 18,
   parameter int BLACK_LEVEL     = 282,
   parameter int WHITE_LEVEL     = 966,
   parameter int TRIGGER_WIDTH   = 256,
   parameter int LUMA_PHASE      = 1
) (
   input  logic                  clock,
   input  logic                  rst_n,
   input  logic [DATA_WIDTH-1:0] sequence_in,
   input  logic                  enable_in,
   output logic [SEQ_BITS-1:0]   sequence_out,
   output logic                  load_out,
   output logic                  valid_out,
   output logic                  error_out
);

   localparam int SAMP_W = (SAMPLES_PER_BIT > 1) ? $clog2(SAMPLES_PER_BIT) : 1;
   localparam int ONES_W = $clog2(SAMPLES_PER_BIT + 1);
   localparam int BIT_W  = $clog2(SEQ_BITS);

   localparam logic [DATA_WIDTH:0] RISE_TH   = (DATA_WIDTH+1)'(WHITE_LEVEL - TRIGGER_WIDTH);
   localparam logic [DATA_WIDTH:0] FALL_TH   = (DATA_WIDTH+1)'(BLACK_LEVEL + TRIGGER_WIDTH);
   localparam logic [SAMP_W-1:0]   SAMP_LAST = SAMP_W'(SAMPLES_PER_BIT - 1);
   localparam logic [BIT_W-1:0]    BIT_LAST  = BIT_W'(SEQ_BITS - 1);
   localparam logic [ONES_W-1:0]   ONES_HALF = ONES_W'(SAMPLES_PER_BIT / 2);
   localparam logic                LUMA_PH   = 1'(LUMA_PHASE);

   if (SEQ_BITS < 2 || SAMPLES_PER_BIT < 1 ||
       (BLACK_LEVEL + TRIGGER_WIDTH) > (WHITE_LEVEL - TRIGGER_WIDTH)) begin : g_param_error
      $error("sequence_detector_n: illegal parameter combination");
   end

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      DONE    = 2'd2
   } state_t;

   state_t                state, state_nxt;
   logic                  phase, phase_nxt;
   logic                  hyst, hyst_nxt;
   logic [SAMP_W-1:0]     samp_cnt, samp_nxt;
   logic [ONES_W-1:0]     ones_cnt, ones_nxt;
   logic [BIT_W-1:0]      bit_cnt, bit_nxt;
   // Final bit goes straight to sequence_out, so only SEQ_BITS-1 bits are held.
   logic [SEQ_BITS-2:0]   shreg, shreg_nxt;
   logic [SEQ_BITS-1:0]   seq_nxt;
   logic                  load_nxt, valid_nxt, error_nxt;

   // On window entry the cycle is processed against cleared state.
   logic                  entry;
   logic                  base_phase, base_h;
   logic [SAMP_W-1:0]     base_samp;
   logic [ONES_W-1:0]     base_ones;
   logic [BIT_W-1:0]      base_bit;
   logic [SEQ_BITS-2:0]   base_shreg;
   logic                  h_new;
   logic [ONES_W-1:0]     ones_sum;
   logic [SEQ_BITS-1:0]   shifted;
   logic [DATA_WIDTH:0]   sample_w;

   assign entry      = (state == IDLE) && enable_in;
   assign base_phase = entry ? 1'b0 : phase;
   assign base_h     = entry ? 1'b0 : hyst;
   assign base_samp  = entry ? '0 : samp_cnt;
   assign base_ones  = entry ? '0 : ones_cnt;
   assign base_bit   = entry ? '0 : bit_cnt;
   assign base_shreg = entry ? '0 : shreg;
   assign sample_w   = {1'b0, sequence_in};

   always_comb begin
      h_new = base_h;
      if (!base_h && (sample_w > RISE_TH)) begin
         h_new = 1'b1;
      end else if (base_h && (sample_w < FALL_TH)) begin
         h_new = 1'b0;
      end
   end

   assign ones_sum = base_ones + ONES_W'(h_new);
   assign shifted  = {base_shreg, (ones_sum > ONES_HALF)};

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         phase        <= 1'b0;
         hyst         <= 1'b0;
         samp_cnt     <= '0;
         ones_cnt     <= '0;
         bit_cnt      <= '0;
         shreg        <= '0;
         sequence_out <= '0;
         load_out     <= 1'b0;
         valid_out    <= 1'b0;
         error_out    <= 1'b0;
      end else begin
         state        <= state_nxt;
         phase        <= phase_nxt;
         hyst         <= hyst_nxt;
         samp_cnt     <= samp_nxt;
         ones_cnt     <= ones_nxt;
         bit_cnt      <= bit_nxt;
         shreg        <= shreg_nxt;
         sequence_out <= seq_nxt;
         load_out     <= load_nxt;
         valid_out    <= valid_nxt;
         error_out    <= error_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      phase_nxt = phase;
      hyst_nxt  = hyst;
      samp_nxt  = samp_cnt;
      ones_nxt  = ones_cnt;
      bit_nxt   = bit_cnt;
      shreg_nxt = shreg;
      seq_nxt   = sequence_out;
      load_nxt  = 1'b0;
      valid_nxt = valid_out;
      error_nxt = 1'b0;

      if (state == DONE) begin
         if (!enable_in) begin
            state_nxt = IDLE;
         end
      end else if (state == COLLECT && !enable_in) begin
         state_nxt = IDLE;
         error_nxt = 1'b1;
      end else if (enable_in) begin
         if (state == IDLE) begin
            state_nxt = COLLECT;
            valid_nxt = 1'b0;
         end
         phase_nxt = ~base_phase;
         hyst_nxt  = base_h;
         samp_nxt  = base_samp;
         ones_nxt  = base_ones;
         bit_nxt   = base_bit;
         shreg_nxt = base_shreg;
         if (base_phase == LUMA_PH) begin
            hyst_nxt = h_new;
            if (base_samp == SAMP_LAST) begin
               samp_nxt  = '0;
               ones_nxt  = '0;
               shreg_nxt = shifted[SEQ_BITS-2:0];
               if (base_bit == BIT_LAST) begin
                  state_nxt = DONE;
                  seq_nxt   = shifted;
                  load_nxt  = 1'b1;
                  valid_nxt = 1'b1;
               end else begin
                  bit_nxt = base_bit + 1'b1;
               end
            end else begin
               samp_nxt = base_samp + 1'b1;
               ones_nxt = ones_sum;
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_sequence_detector_n.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// tb_sequence_detector_n : scoreboard bench for two configurations of the detector
// Revision: 1.0
// ============================================================================
module tb_sequence_detector_n;

   localparam int HI_TH = 966 - 256;
   localparam int LO_TH = 282 + 256;

   logic        clk = 1'b0;
   logic        rst_a_n, rst_b_n, en_a, en_b;
   logic [9:0]  seq_a, seq_b;
   logic [31:0] out_a;
   logic [7:0]  out_b;
   logic        load_a, valid_a, err_a, load_b, valid_b, err_b;

   always #5 clk = ~clk;

   sequence_detector_n u_dut_a (
      .clock(clk), .rst_n(rst_a_n), .sequence_in(seq_a), .enable_in(en_a),
      .sequence_out(out_a), .load_out(load_a), .valid_out(valid_a), .error_out(err_a)
   );

   sequence_detector_n #(.SEQ_BITS(8), .SAMPLES_PER_BIT(4), .LUMA_PHASE(0)) u_dut_b (
      .clock(clk), .rst_n(rst_b_n), .sequence_in(seq_b), .enable_in(en_b),
      .sequence_out(out_b), .load_out(load_b), .valid_out(valid_b), .error_out(err_b)
   );

   typedef struct {
      bit          is_load;
      logic [31:0] word;
      int          due;
   } ev_t;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   ev_t         exp_a[$], exp_b[$];
   int          luma_a[$], luma_b[$];
   bit          inwin[2], done[2], exp_valid[2];
   int          kidx[2];
   logic [31:0] last_word[2];

   always @(posedge clk) cyc <= cyc + 1;

   function automatic int nbits(input int sel); return (sel != 0) ? 8 : 32; endfunction
   function automatic int spb(input int sel);   return (sel != 0) ? 4 : 18; endfunction
   function automatic int lph(input int sel);   return (sel != 0) ? 0 : 1;  endfunction

   function automatic logic [31:0] get_word(input int sel);
      return (sel != 0) ? {24'd0, out_b} : out_a;
   endfunction
   function automatic logic get_valid(input int sel);
      return (sel != 0) ? valid_b : valid_a;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   // Slice, integrate and majority-vote a list of luma samples straight from the rules.
   function automatic logic [31:0] model_word(input int l[$], input int n);
      bit          h;
      int          ones;
      logic [31:0] w;
      h = 0; ones = 0; w = 0;
      foreach (l[i]) begin
         if (!h && l[i] > HI_TH) h = 1;
         else if (h && l[i] < LO_TH) h = 0;
         ones += int'(h);
         if ((i % n) == n - 1) begin
            w = {w[30:0], (ones > n / 2)};
            ones = 0;
         end
      end
      return w;
   endfunction

   task automatic push_ev(input int sel, input bit ld, input logic [31:0] w);
      ev_t e;
      e.is_load = ld; e.word = w; e.due = cyc + 1;
      if (sel != 0) exp_b.push_back(e); else exp_a.push_back(e);
   endtask

   task automatic model_step(input int sel, input logic [9:0] s, input bit en);
      logic [31:0] w;
      int          cnt;
      if (en) begin
         if (!inwin[sel]) begin
            chk("idle_valid", 32'(get_valid(sel)), 32'(exp_valid[sel]));
            chk("idle_word", get_word(sel), last_word[sel]);
            inwin[sel] = 1; done[sel] = 0; kidx[sel] = 0; exp_valid[sel] = 0;
            if (sel != 0) luma_b.delete(); else luma_a.delete();
         end
         if (!done[sel] && (kidx[sel] % 2) == lph(sel)) begin
            if (sel != 0) begin luma_b.push_back(int'(s)); cnt = luma_b.size(); end
            else begin luma_a.push_back(int'(s)); cnt = luma_a.size(); end
            if (cnt == nbits(sel) * spb(sel)) begin
               w = (sel != 0) ? model_word(luma_b, spb(sel)) : model_word(luma_a, spb(sel));
               push_ev(sel, 1, w);
               last_word[sel] = w; exp_valid[sel] = 1; done[sel] = 1;
            end
         end
         kidx[sel]++;
      end else if (inwin[sel]) begin
         inwin[sel] = 0;
         if (!done[sel]) push_ev(sel, 0, last_word[sel]);
      end
   endtask

   // Called at a negedge: drive, record, then advance one cycle.
   task automatic drive(input int sel, input logic [9:0] s, input bit en);
      if (sel != 0) begin seq_b = s; en_b = en; end
      else begin seq_a = s; en_a = en; end
      model_step(sel, s, en);
      @(negedge clk);
   endtask

   function automatic logic [9:0] luma_val(input int mode, input logic [31:0] word,
                                           input int sel, input int j);
      int   nb, n, b, m, cnt;
      int   pick[7];
      nb = nbits(sel); n = spb(sel); b = j / n; m = j % n;
      pick = '{282, 537, 540, 600, 705, 715, 966};
      if (b >= nb) return 10'($urandom_range(0, 1023));
      case (mode)
         0: return word[nb-1-b] ? 10'd966 : 10'd282;
         2: return (j == 0) ? 10'd966 : 10'($urandom_range(600, 700));
         3: begin
            cnt = word[nb-1-b] ? n / 2 + 1 : n / 2;
            return (m < cnt) ? 10'd966 : 10'd282;
         end
         4: return 10'(pick[$urandom_range(0, 6)]);
         default: return 10'($urandom_range(0, 1023));
      endcase
   endfunction

   task automatic run_window(input int sel, input int mode, input logic [31:0] word,
                             input int len, input bit alt_chroma, input bit close);
      logic [9:0] s;
      for (int k = 0; k < len; k++) begin
         if ((k % 2) == lph(sel)) s = luma_val(mode, word, sel, k / 2);
         else if (alt_chroma) s = ((k / 2) % 2 != 0) ? 10'd1023 : 10'd0;
         else s = 10'd512;
         drive(sel, s, 1'b1);
      end
      if (close) begin
         drive(sel, 10'($urandom_range(0, 1023)), 1'b0);
         drive(sel, 10'($urandom_range(0, 1023)), 1'b0);
      end
   endtask

   task automatic mon(input int sel, input logic ld, input logic er,
                      input logic [31:0] w, input logic v);
      ev_t e;
      if (ld || er) begin
         if ((sel != 0 ? exp_b.size() : exp_a.size()) == 0) begin
            chk("unexpected_event", 32'({ld, er}), 32'd0);
         end else begin
            e = (sel != 0) ? exp_b.pop_front() : exp_a.pop_front();
            chk("event_kind", 32'({ld, er}), e.is_load ? 32'd2 : 32'd1);
            chk("event_cycle", 32'(cyc), 32'(e.due));
            chk("event_word", w, e.word);
            chk("event_valid", 32'(v), 32'(e.is_load));
         end
      end
   endtask

   always @(negedge clk) begin
      if (rst_a_n === 1'b1) mon(0, load_a, err_a, out_a, valid_a);
      if (rst_b_n === 1'b1) mon(1, load_b, err_b, {24'd0, out_b}, valid_b);
   end

   task automatic check_zero(input int sel);
      chk("rst_word",  get_word(sel), 32'd0);
      chk("rst_load",  32'((sel != 0) ? load_b : load_a), 32'd0);
      chk("rst_valid", 32'(get_valid(sel)), 32'd0);
      chk("rst_error", 32'((sel != 0) ? err_b : err_a), 32'd0);
   endtask

   initial begin
      rst_a_n = 1'b0; rst_b_n = 1'b0; en_a = 1'b0; en_b = 1'b0; seq_a = '0; seq_b = '0;
      for (int i = 0; i < 2; i++) begin
         inwin[i] = 0; done[i] = 0; exp_valid[i] = 0; kidx[i] = 0; last_word[i] = 0;
      end
      repeat (2) @(negedge clk);
      check_zero(0);
      check_zero(1);
      rst_a_n = 1'b1; rst_b_n = 1'b1;
      @(negedge clk);

      // Configuration A: 32 bits, 18 samples per bit, luma on phase 1.
      run_window(0, 0, 32'hA5C3_0F81, 1152 + 6, 1'b0, 1'b1);
      run_window(0, 2, 32'd0, 1152, 1'b0, 1'b1);
      run_window(0, 3, $urandom, 1152, 1'b1, 1'b1);
      run_window(0, 4, 32'd0, 1152, 1'b1, 1'b1);
      run_window(0, 1, 32'd0, 1152, 1'b0, 1'b1);
      run_window(0, 1, 32'd0, 20 * 36, 1'b0, 1'b1);
      run_window(0, 0, $urandom, 1152, 1'b1, 1'b1);
      run_window(0, 1, 32'd0, 1151, 1'b0, 1'b1);
      run_window(0, 3, $urandom, 1152, 1'b0, 1'b1);

      // Configuration B: 8 bits, 4 samples per bit, luma on phase 0.
      run_window(1, 1, 32'd0, 64, 1'b0, 1'b1);
      run_window(1, 4, 32'd0, 20, 1'b0, 1'b0);
      #2 rst_b_n = 1'b0;
      #1 check_zero(1);
      inwin[1] = 0; done[1] = 0; exp_valid[1] = 0; last_word[1] = 0;
      @(negedge clk);
      rst_b_n = 1'b1;
      run_window(1, 0, {24'd0, 8'($urandom)}, 64, 1'b1, 1'b1);
      for (int i = 0; i < 8; i++) begin
         run_window(1, int'($urandom_range(0, 4)), {24'd0, 8'($urandom)},
                    int'($urandom_range(40, 72)), 1'($urandom), 1'b1);
      end

      repeat (4) drive(1, 10'd0, 1'b0);
      chk("pending_a", 32'(exp_a.size()), 32'd0);
      chk("pending_b", 32'(exp_b.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
